// File: rtl/meter_pkg.sv
// rtl/meter_pkg.sv - pixel colour type, palette constants and the height-zone colour helper.
package meter_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_RED  = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb_t COL_YEL  = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t COL_GRN  = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb_t COL_PEAK = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t COL_BG   = '{r: 4'h1, g: 4'h1, b: 4'h3};
  localparam rgb_t COL_OFF  = '{r: 4'h0, g: 4'h0, b: 4'h0};

  // Rows above red_y are red, rows above yel_y are yellow, the rest green.
  function automatic rgb_t zone_colour(input logic [9:0] y, input logic [9:0] red_y,
                                       input logic [9:0] yel_y);
    rgb_t c;
    if (y < red_y)      c = COL_RED;
    else if (y < yel_y) c = COL_YEL;
    else                c = COL_GRN;
    return c;
  endfunction

endpackage

// File: rtl/meter_ballistics.sv
// rtl/meter_ballistics.sv - per-channel displayed height and peak-hold update, once per frame.
// Peak and hold registers exist only when METER_PEAK_MARKER_EN is defined.
module meter_ballistics
  import meter_pkg::*;
#(
  parameter int LVL_W       = 9,
  parameter int MAX_H       = 300,
  parameter int DECAY_STEP  = 4,
  parameter int HOLD_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] disp
`ifdef METER_PEAK_MARKER_EN
  ,
  output logic [LVL_W-1:0] peak
`endif
);

  localparam logic [LVL_W-1:0] MAX_HV = LVL_W'(MAX_H);
  localparam logic [LVL_W-1:0] DEC    = LVL_W'(DECAY_STEP);

  logic [LVL_W-1:0] n;
  logic [LVL_W-1:0] disp_dec;
  logic [LVL_W-1:0] disp_next;

  // Release is clamped at zero first, then floored at the incoming level.
  always_comb begin
    n         = (level > MAX_HV) ? MAX_HV : level;
    disp_dec  = (disp > DEC) ? disp - DEC : '0;
    disp_next = n;
    if (n < disp) disp_next = (disp_dec > n) ? disp_dec : n;
  end

  always_ff @(posedge clk) begin
    if (reset)       disp <= '0;
    else if (update) disp <= disp_next;
  end

`ifdef METER_PEAK_MARKER_EN
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [HOLD_W-1:0] hold;
  logic [LVL_W-1:0]  peak_dec;

  assign peak_dec = (peak > DEC) ? peak - DEC : '0;

  // Falling peak is floored at the new displayed height so it never sits inside the bar.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak <= '0;
      hold <= '0;
    end else if (update) begin
      if (n >= peak) begin
        peak <= n;
        hold <= HOLD_W'(HOLD_FRAMES);
      end else if (hold != '0) begin
        hold <= hold - HOLD_W'(1);
      end else begin
        peak <= (peak_dec > disp_next) ? peak_dec : disp_next;
      end
    end
  end
`endif

endmodule

// File: rtl/meter_overlay.sv
// rtl/meter_overlay.sv - N_CH vertical level meters drawn over the VGA raster, 2-cycle pixel pipeline.
// Define METER_PEAK_MARKER_EN to build the peak-hold marker rows.
module meter_overlay
  import meter_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int LVL_W       = 9,
  parameter int MAX_H       = 300,
  parameter int BASE_Y      = 400,
  parameter int BAR_X0      = 220,
  parameter int BAR_W       = 80,
  parameter int BAR_GAP     = 40,
  parameter int RED_Y       = 200,
  parameter int YEL_Y       = 300,
  parameter int DECAY_STEP  = 4,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [N_CH*LVL_W-1:0] level,
  input  logic [9:0]            draw_x,
  input  logic [9:0]            draw_y,
  input  logic                  de,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  de_out
);

  localparam int PITCH = BAR_W + BAR_GAP;

  logic [LVL_W-1:0] disp [N_CH];
`ifdef METER_PEAK_MARKER_EN
  logic [LVL_W-1:0] peak [N_CH];
`endif

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    meter_ballistics #(
      .LVL_W      (LVL_W),
      .MAX_H      (MAX_H),
      .DECAY_STEP (DECAY_STEP),
      .HOLD_FRAMES(HOLD_FRAMES)
    ) u_bal (
      .clk   (clk),
      .reset (reset),
      .update(frame_start),
      .level (level[gi*LVL_W +: LVL_W]),
      .disp  (disp[gi])
`ifdef METER_PEAK_MARKER_EN
      ,
      .peak  (peak[gi])
`endif
    );
  end

  int   px;
  int   py;
  logic in_bar;
  logic peak_row;

  // Channel columns are disjoint, so at most one iteration matches.
  always_comb begin
    px       = int'(draw_x);
    py       = int'(draw_y);
    in_bar   = 1'b0;
    peak_row = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (px >= BAR_X0 + i * PITCH && px < BAR_X0 + i * PITCH + BAR_W) begin
        in_bar = (py <= BASE_Y) && (py + int'(disp[i]) > BASE_Y);
`ifdef METER_PEAK_MARKER_EN
        peak_row = (peak[i] != '0) && (py + int'(peak[i]) == BASE_Y);
`endif
      end
    end
  end

  logic       s1_de;
  logic [9:0] s1_y;
  logic       s1_in_bar;
  logic       s1_peak_row;
  rgb_t       pix;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de       <= 1'b0;
      s1_y        <= '0;
      s1_in_bar   <= 1'b0;
      s1_peak_row <= 1'b0;
    end else begin
      s1_de       <= de;
      s1_y        <= draw_y;
      s1_in_bar   <= in_bar;
      s1_peak_row <= peak_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix    <= COL_OFF;
      de_out <= 1'b0;
    end else begin
      de_out <= s1_de;
      if (!s1_de)           pix <= COL_OFF;
      else if (s1_peak_row) pix <= COL_PEAK;
      else if (s1_in_bar)   pix <= zone_colour(s1_y, 10'(RED_Y), 10'(YEL_Y));
      else                  pix <= COL_BG;
    end
  end

  assign red   = pix.r;
  assign green = pix.g;
  assign blue  = pix.b;

endmodule

// File: tb/tb_meter_overlay.sv
// tb/tb_meter_overlay.sv - directed and randomized bench for meter_overlay against a frame-level model.
module tb_meter_overlay;

  localparam int N_CH = 2, LVL_W = 9, MAX_H = 300, BASE_Y = 400, BAR_X0 = 220;
  localparam int BAR_W = 80, BAR_GAP = 40, RED_Y = 200, YEL_Y = 300;
  localparam int DECAY_STEP = 4, HOLD_FRAMES = 30;
`ifdef METER_PEAK_MARKER_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  frame_start = 1'b0;
  logic [N_CH*LVL_W-1:0] level = '0;
  logic [9:0]            draw_x = '0;
  logic [9:0]            draw_y = '0;
  logic                  de = 1'b0;
  logic [3:0]            red, green, blue;
  logic                  de_out;

  int checks = 0;
  int failures = 0;
  int lv[N_CH];
  int m_disp[N_CH];
  int m_peak[N_CH];
  int m_hold[N_CH];

  meter_overlay #(
    .N_CH(N_CH), .LVL_W(LVL_W), .MAX_H(MAX_H), .BASE_Y(BASE_Y), .BAR_X0(BAR_X0),
    .BAR_W(BAR_W), .BAR_GAP(BAR_GAP), .RED_Y(RED_Y), .YEL_Y(YEL_Y),
    .DECAY_STEP(DECAY_STEP), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .level(level),
    .draw_x(draw_x), .draw_y(draw_y), .de(de),
    .red(red), .green(green), .blue(blue), .de_out(de_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_disp[i] = 0;
      m_peak[i] = 0;
      m_hold[i] = 0;
    end
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < N_CH; i++) begin
      int n;
      n = (lv[i] > MAX_H) ? MAX_H : lv[i];
      if (n >= m_disp[i]) m_disp[i] = n;
      else m_disp[i] = (m_disp[i] - DECAY_STEP > n) ? m_disp[i] - DECAY_STEP : n;
      if (n >= m_peak[i]) begin
        m_peak[i] = n;
        m_hold[i] = HOLD_FRAMES;
      end else if (m_hold[i] != 0) begin
        m_hold[i]--;
      end else begin
        m_peak[i] = (m_peak[i] - DECAY_STEP > m_disp[i]) ? m_peak[i] - DECAY_STEP : m_disp[i];
      end
    end
  endfunction

  // Expected {de_out, r, g, b} for a pixel under the current model heights.
  function automatic logic [12:0] exp_pix(input int x, input int y, input bit d);
    int ch;
    ch = -1;
    if (!d) return 13'h0000;
    for (int i = 0; i < N_CH; i++)
      if (x >= BAR_X0 + i * (BAR_W + BAR_GAP) && x < BAR_X0 + i * (BAR_W + BAR_GAP) + BAR_W) ch = i;
    if (ch < 0) return 13'h1113;
    if (PEAK_EN && m_peak[ch] != 0 && y == BASE_Y - m_peak[ch]) return 13'h1FFF;
    if (y <= BASE_Y && y > BASE_Y - m_disp[ch]) begin
      if (y < RED_Y) return 13'h1F00;
      if (y < YEL_Y) return 13'h1FF0;
      return 13'h10F0;
    end
    return 13'h1113;
  endfunction

  // Present a pixel, replace it with a random one next cycle, then expect the first one's colour.
  task automatic check_pixel(input string tag, input int x, input int y, input bit d);
    logic [12:0] exp;
    @(negedge clk);
    draw_x = 10'(x);
    draw_y = 10'(y);
    de     = d;
    exp    = exp_pix(x, y, d);
    @(negedge clk);
    draw_x = 10'($urandom_range(0, 639));
    draw_y = 10'($urandom_range(0, 479));
    de     = 1'($urandom_range(0, 1));
    @(negedge clk);
    check(tag, {de_out, red, green, blue}, exp);
  endtask

  task automatic drive_levels();
    for (int i = 0; i < N_CH; i++) level[i*LVL_W +: LVL_W] = LVL_W'(lv[i]);
  endtask

  task automatic do_frame();
    @(negedge clk);
    drive_levels();
    frame_start = 1'b1;
    de = 1'b0;
    model_frame();
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_double_frame();
    @(negedge clk);
    drive_levels();
    frame_start = 1'b1;
    model_frame();
    @(negedge clk);
    for (int i = 0; i < N_CH; i++) lv[i] = $urandom_range(0, 511);
    drive_levels();
    model_frame();
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N_CH; i++) lv[i] = 0;
    repeat (3) @(negedge clk);
    check("reset_out", {de_out, red, green, blue}, 13'h0000);
    reset = 1'b0;

    lv[0] = 100;
    do_frame();
    check_pixel("l100_green", 230, 301, 1'b1);
    check_pixel("l100_top", 230, 300, 1'b1);
    check_pixel("l100_base", 230, 400, 1'b1);
    check_pixel("l100_below", 230, 401, 1'b1);

    lv[0] = 0;
    for (int f = 0; f < 40; f++) begin
      do_frame();
      if (m_disp[0] > 0) check_pixel("decay_in", 230, BASE_Y - m_disp[0] + 1, 1'b1);
      check_pixel("decay_edge", 299, BASE_Y - m_disp[0], 1'b1);
      if (m_peak[0] > 0) check_pixel("peak_row", 250, BASE_Y - m_peak[0], 1'b1);
    end

    lv[0] = 511;
    do_frame();
    check_pixel("clamp_red", 230, 101, 1'b1);
    check_pixel("clamp_top", 230, 100, 1'b1);
    check_pixel("clamp_yel", 230, 250, 1'b1);
    check_pixel("clamp_grn", 230, 350, 1'b1);

    lv[0] = 0;
    lv[1] = 50;
    do_frame();
    check_pixel("ch1_grn", 345, 360, 1'b1);
    check_pixel("gap", 310, 360, 1'b1);
    check_pixel("ch0_base", 230, 399, 1'b1);
    check_pixel("ch1_left", 340, 390, 1'b1);
    check_pixel("ch1_right", 420, 390, 1'b1);
    check_pixel("ch0_right", 300, 390, 1'b1);

    for (int k = 0; k < 6; k++)
      check_pixel("de_low", $urandom_range(0, 639), $urandom_range(0, 479), 1'b0);

    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N_CH; i++)
        lv[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 320);
      if (f % 7 == 3) do_double_frame();
      else do_frame();
      for (int k = 0; k < 4; k++)
        check_pixel("rand", $urandom_range(200, 480), $urandom_range(80, 420), 1'($urandom_range(0, 7) != 0));
    end

    lv[0] = 200;
    lv[1] = 200;
    do_frame();
    @(negedge clk);
    reset = 1'b1;
    frame_start = 1'b1;
    de = 1'b1;
    draw_x = 10'd230;
    draw_y = 10'd350;
    @(negedge clk);
    check("rst_mid_out", {de_out, red, green, blue}, 13'h0000);
    model_reset();
    reset = 1'b0;
    frame_start = 1'b0;
    check_pixel("rst_ch0", 230, 399, 1'b1);
    check_pixel("rst_ch1", 350, 350, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
